// File: rtl/mtf_pkg.sv
// Shared types and widths for the MTF neuron spike post-processing stage.
package mtf_pkg;

  localparam int unsigned RATE_W            = 8;
  localparam int unsigned BURST_LEN_W       = 8;
  localparam int unsigned PERIOD_W          = 16;
  localparam int unsigned WIN_W             = 16;
  localparam int unsigned GAP_W             = 8;
  localparam int unsigned WINDOW_CYCLES_DEF = 1000;
  localparam int unsigned GAP_CYCLES_DEF    = 64;

  typedef enum logic {
    QUIET = 1'b0,
    BURST = 1'b1
  } burst_state_t;

  // Increment an 8-bit counter, sticking at all-ones.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/spike_burst_fsm.sv
// Burst detector: tracks burst length, inter-spike gap and start-to-start period.
module spike_burst_fsm
  import mtf_pkg::*;
#(
  parameter int unsigned GAP_CYCLES = GAP_CYCLES_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   spike,
  output logic                   burst_active,
  output logic                   burst_done,
  output logic [BURST_LEN_W-1:0] burst_len,
  output logic [PERIOD_W-1:0]    burst_period
);

  // Gap counter value on the cycle that completes the silent run.
  localparam logic [GAP_W-1:0]    GAP_LAST   = GAP_W'(GAP_CYCLES - 1);
  localparam logic [PERIOD_W-1:0] PERIOD_MAX = '1;

  burst_state_t           state;
  logic [BURST_LEN_W-1:0] len_cnt;
  logic [GAP_W-1:0]       gap_cnt;
  logic [PERIOD_W-1:0]    period_cnt;
  logic [PERIOD_W-1:0]    pending_period;

  // Burst state machine with its counters and registered result outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= QUIET;
      len_cnt        <= '0;
      gap_cnt        <= '0;
      period_cnt     <= PERIOD_MAX;
      pending_period <= PERIOD_MAX;
      burst_active   <= 1'b0;
      burst_done     <= 1'b0;
      burst_len      <= '0;
      burst_period   <= PERIOD_MAX;
    end else begin
      burst_done <= 1'b0;
      if (period_cnt != PERIOD_MAX) begin
        period_cnt <= period_cnt + PERIOD_W'(1);
      end
      case (state)
        QUIET: begin
          if (spike) begin
            state          <= BURST;
            burst_active   <= 1'b1;
            len_cnt        <= BURST_LEN_W'(1);
            gap_cnt        <= '0;
            pending_period <= period_cnt;
            period_cnt     <= PERIOD_W'(1);
          end
        end
        BURST: begin
          if (spike) begin
            len_cnt <= sat_inc8(len_cnt);
            gap_cnt <= '0;
          end else if (gap_cnt == GAP_LAST) begin
            state        <= QUIET;
            burst_active <= 1'b0;
            burst_done   <= 1'b1;
            burst_len    <= len_cnt;
            burst_period <= pending_period;
            gap_cnt      <= '0;
          end else begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/spike_train_decoder.sv
// Converts the neuron spike stream into windowed firing rate and burst metrics.
module spike_train_decoder
  import mtf_pkg::*;
#(
  parameter int unsigned WINDOW_CYCLES = WINDOW_CYCLES_DEF,
  parameter int unsigned GAP_CYCLES    = GAP_CYCLES_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   spike,
  output logic [RATE_W-1:0]      rate,
  output logic                   rate_valid,
  input  logic                   rate_ready,
  output logic                   rate_overrun,
  output logic                   burst_active,
  output logic                   burst_done,
  output logic [BURST_LEN_W-1:0] burst_len,
  output logic [PERIOD_W-1:0]    burst_period
);

  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW_CYCLES - 1);

  logic [WIN_W-1:0]  win_cnt;
  logic [RATE_W-1:0] spike_cnt;
  logic              win_last_c;
  logic              handshake_c;
  logic [RATE_W-1:0] cnt_next_c;

  // Window end, accepted sample, and the count including this cycle's spike.
  always_comb begin
    win_last_c  = (win_cnt == WIN_LAST);
    handshake_c = rate_valid && rate_ready;
    cnt_next_c  = spike ? sat_inc8(spike_cnt) : spike_cnt;
  end

  // Window counter and per-window spike count.
  always_ff @(posedge clk) begin
    if (reset) begin
      win_cnt   <= '0;
      spike_cnt <= '0;
    end else if (win_last_c) begin
      win_cnt   <= '0;
      spike_cnt <= '0;
    end else begin
      win_cnt   <= win_cnt + WIN_W'(1);
      spike_cnt <= cnt_next_c;
    end
  end

  // Rate sample buffer with valid/ready handshake and sticky overrun.
  always_ff @(posedge clk) begin
    if (reset) begin
      rate         <= '0;
      rate_valid   <= 1'b0;
      rate_overrun <= 1'b0;
    end else if (win_last_c) begin
      rate       <= cnt_next_c;
      rate_valid <= 1'b1;
      if (rate_valid && !rate_ready) begin
        rate_overrun <= 1'b1;
      end
    end else if (handshake_c) begin
      rate_valid <= 1'b0;
    end
  end

  spike_burst_fsm #(
    .GAP_CYCLES(GAP_CYCLES)
  ) u_burst (
    .clk         (clk),
    .reset       (reset),
    .spike       (spike),
    .burst_active(burst_active),
    .burst_done  (burst_done),
    .burst_len   (burst_len),
    .burst_period(burst_period)
  );

endmodule

// File: tb/tb_spike_train_decoder.sv
// Directed self-checking bench for spike_train_decoder (short window and long window instances).
module tb_spike_train_decoder;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: WINDOW_CYCLES=16, GAP_CYCLES=4
  logic        reset_a, spike_a, ready_a;
  logic [7:0]  rate_a, len_a;
  logic [15:0] period_a;
  logic        valid_a, overrun_a, active_a, done_a;

  // Instance B: WINDOW_CYCLES=300, GAP_CYCLES=4
  logic        reset_b, spike_b, ready_b;
  logic [7:0]  rate_b, len_b;
  logic [15:0] period_b;
  logic        valid_b, overrun_b, active_b, done_b;

  int checks = 0;
  int errors = 0;

  spike_train_decoder #(.WINDOW_CYCLES(16), .GAP_CYCLES(4)) dut_a (
    .clk(clk), .reset(reset_a), .spike(spike_a),
    .rate(rate_a), .rate_valid(valid_a), .rate_ready(ready_a), .rate_overrun(overrun_a),
    .burst_active(active_a), .burst_done(done_a), .burst_len(len_a), .burst_period(period_a)
  );

  spike_train_decoder #(.WINDOW_CYCLES(300), .GAP_CYCLES(4)) dut_b (
    .clk(clk), .reset(reset_b), .spike(spike_b),
    .rate(rate_b), .rate_valid(valid_b), .rate_ready(ready_b), .rate_overrun(overrun_b),
    .burst_active(active_b), .burst_done(done_b), .burst_len(len_b), .burst_period(period_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_a(input string tag);
    chk({tag, "_rate"},    32'(rate_a),    32'h0);
    chk({tag, "_valid"},   32'(valid_a),   32'h0);
    chk({tag, "_overrun"}, 32'(overrun_a), 32'h0);
    chk({tag, "_active"},  32'(active_a),  32'h0);
    chk({tag, "_done"},    32'(done_a),    32'h0);
    chk({tag, "_len"},     32'(len_a),     32'h0);
    chk({tag, "_period"},  32'(period_a),  32'hFFFF);
  endtask

  initial begin
    logic saw_done, saw_valid;
    int   n;

    reset_a = 1'b1; spike_a = 1'b0; ready_a = 1'b1;
    reset_b = 1'b1; spike_b = 1'b0; ready_b = 1'b1;
    repeat (2) step();
    chk_reset_a("rst");

    // Bursts: spikes at 10,11,13 then a lone spike at 30.
    reset_a  = 1'b0;
    saw_done = 1'b0;
    for (int c = 0; c < 40; c++) begin
      spike_a = (c == 10 || c == 11 || c == 13 || c == 30);
      step();
      n = c + 1;
      if (n == 11) chk("b1_active", 32'(active_a), 32'h1);
      if (n == 16) begin
        chk("w0_valid", 32'(valid_a), 32'h1);
        chk("w0_rate",  32'(rate_a),  32'h3);
      end
      if (n == 17) begin
        chk("w0_valid_drop", 32'(valid_a), 32'h0);
        chk("b1_done_early", 32'(done_a),  32'h0);
      end
      if (n == 18) begin
        chk("b1_done",   32'(done_a),   32'h1);
        chk("b1_len",    32'(len_a),    32'h3);
        chk("b1_period", 32'(period_a), 32'hFFFF);
        chk("b1_idle",   32'(active_a), 32'h0);
      end
      if (n >= 19 && n <= 34 && done_a) saw_done = 1'b1;
      if (n == 32) chk("w1_rate", 32'(rate_a), 32'h1);
      if (n == 35) begin
        chk("b2_done",   32'(done_a),   32'h1);
        chk("b2_len",    32'(len_a),    32'h1);
        chk("b2_period", 32'(period_a), 32'd20);
      end
      if (n == 36) chk("b2_done_pulse", 32'(done_a), 32'h0);
    end
    chk("b_no_spurious_done", 32'(saw_done), 32'h0);

    // Rate: every 4th cycle, then two unconsumed windows with 3 and 5 spikes.
    reset_a = 1'b1; spike_a = 1'b0;
    step();
    reset_a = 1'b0;
    for (int c = 0; c < 96; c++) begin
      ready_a = !(c >= 48 && c < 80);
      if (c < 48)      spike_a = (c % 4 == 0);
      else if (c < 64) spike_a = (c == 48 || c == 52 || c == 56);
      else if (c < 80) spike_a = (c == 64 || c == 66 || c == 68 || c == 70 || c == 72);
      else             spike_a = 1'b0;
      step();
      n = c + 1;
      if (n == 16) begin
        chk("r0_rate",  32'(rate_a),  32'h4);
        chk("r0_valid", 32'(valid_a), 32'h1);
      end
      if (n == 17) chk("r0_pulse", 32'(valid_a), 32'h0);
      if (n == 32) chk("r1_rate", 32'(rate_a), 32'h4);
      if (n == 48) begin
        chk("r2_rate",    32'(rate_a),    32'h4);
        chk("r2_valid",   32'(valid_a),   32'h1);
        chk("r2_overrun", 32'(overrun_a), 32'h0);
      end
      if (n == 64) begin
        chk("r3_rate",    32'(rate_a),    32'h3);
        chk("r3_valid",   32'(valid_a),   32'h1);
        chk("r3_overrun", 32'(overrun_a), 32'h1);
      end
      if (n == 70) chk("r3_stable", 32'(rate_a), 32'h3);
      if (n == 80) begin
        chk("r4_rate",    32'(rate_a),    32'h5);
        chk("r4_valid",   32'(valid_a),   32'h1);
        chk("r4_overrun", 32'(overrun_a), 32'h1);
      end
      if (n == 81) begin
        chk("r4_consumed",      32'(valid_a),   32'h0);
        chk("r4_overrun_stick", 32'(overrun_a), 32'h1);
      end
    end

    // Reset in cycle 12 of a burst that is also mid-window.
    ready_a = 1'b1;
    reset_a = 1'b1; spike_a = 1'b0;
    step();
    reset_a = 1'b0;
    for (int c = 0; c < 12; c++) begin
      spike_a = 1'b1;
      step();
      if (c == 9) chk("mid_active", 32'(active_a), 32'h1);
    end
    reset_a = 1'b1;
    step();
    chk_reset_a("mid_rst");
    reset_a   = 1'b0;
    spike_a   = 1'b0;
    saw_done  = 1'b0;
    saw_valid = 1'b0;
    for (int c = 0; c < 16; c++) begin
      step();
      if (done_a) saw_done = 1'b1;
      if (c < 15 && valid_a) saw_valid = 1'b1;
    end
    chk("mid_no_done",  32'(saw_done),  32'h0);
    chk("mid_no_valid", 32'(saw_valid), 32'h0);
    chk("mid_w_valid",  32'(valid_a),   32'h1);
    chk("mid_w_rate",   32'(rate_a),    32'h0);

    // Long window with spike tied high: rate and burst length saturate.
    reset_b  = 1'b0;
    spike_b  = 1'b1;
    saw_done = 1'b0;
    for (int c = 0; c < 300; c++) begin
      step();
      if (done_b) saw_done = 1'b1;
      if (c == 149) chk("sat_active_mid", 32'(active_b), 32'h1);
    end
    chk("sat_rate",    32'(rate_b),   32'd255);
    chk("sat_valid",   32'(valid_b),  32'h1);
    chk("sat_active",  32'(active_b), 32'h1);
    chk("sat_no_done", 32'(saw_done), 32'h0);
    spike_b = 1'b0;
    repeat (3) step();
    chk("sat_done_early", 32'(done_b), 32'h0);
    step();
    chk("sat_done",   32'(done_b),   32'h1);
    chk("sat_len",    32'(len_b),    32'd255);
    chk("sat_period", 32'(period_b), 32'hFFFF);
    step();
    chk("sat_done_pulse", 32'(done_b), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spike_train_decoder.md
# spike_train_decoder

Downstream stage of the MTF neuron: consumes the neuron's single-bit `spike` output and turns it into quantities the gait/servo logic can use. It measures the firing rate over fixed windows and detects bursts (the neuron's oscillatory on-phases), reporting burst length and start-to-start burst period. Rate samples go out through a valid/ready handshake; burst results are a one-cycle event with held data.

## Interface
Parameters:
- `WINDOW_CYCLES`, default 1000: clock cycles per rate window, legal range 2..65535.
- `GAP_CYCLES`, default 64: number of consecutive spike-free cycles that ends a burst, legal range 1..255.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high reset.
- `spike`  in  1  neuron spike; sampled every cycle, one cycle high counts as one spike.
- `rate`  out  8  spikes counted in the last completed window, saturating at 255.
- `rate_valid`  out  1  `rate` holds an unconsumed sample.
- `rate_ready`  in  1  consumer accepts `rate` when `rate_valid && rate_ready`.
- `rate_overrun`  out  1  sticky; set when an unconsumed sample is overwritten.
- `burst_active`  out  1  burst FSM is in BURST.
- `burst_done`  out  1  one-cycle pulse when a burst ends.
- `burst_len`  out  8  spikes in the last completed burst, saturating at 255.
- `burst_period`  out  16  cycles from the previous burst start to the start of the last completed burst, saturating at 0xFFFF.

## Operation
- Reset values: `rate`=0, `rate_valid`=0, `rate_overrun`=0, `burst_active`=0, `burst_done`=0, `burst_len`=0, `burst_period`=0xFFFF. Internal window counter=0, spike count=0, period counter=0xFFFF (saturated), FSM=QUIET.
- Rate path:
  - The window counter runs 0..WINDOW_CYCLES-1 and wraps.
  - The spike count increments on each `spike` cycle and saturates at 255.
  - On the final window cycle, the count including that cycle's spike is loaded into `rate`. The count then restarts at 0, and a spike in the first cycle of the next window counts toward that window.
  - Load while `rate_valid=0`, or while a handshake completes in the same cycle: `rate_valid` ends the cycle at 1 and `rate_overrun` is unchanged.
  - Load while `rate_valid=1` and `rate_ready=0`: the old sample is overwritten and `rate_overrun` is set. It clears only on reset.
  - Handshake with no load: `rate_valid` goes to 0 next cycle.
  - `rate` is stable while `rate_valid=1`, except on overwrite.
- Burst FSM, states QUIET and BURST:
  - QUIET, `spike`=1: go to BURST. Length counter=1, gap counter=0. The period counter value is captured as the pending period, then the period counter restarts at 1.
  - BURST, `spike`=1: length counter +1 (saturating at 255), gap counter=0.
  - BURST, `spike`=0: gap counter +1. When the gap counter reaches GAP_CYCLES, go to QUIET. `burst_len`←length counter, `burst_period`←pending period, `burst_done`=1 for one cycle.
  - The period counter increments every cycle and saturates at 0xFFFF. Its post-reset saturated value means the first burst after reset reports `burst_period`=0xFFFF.
- `burst_active` mirrors the BURST state.

## Timing
- All outputs are registered. There is no input register on `spike`.
- `rate_valid` rises the cycle after the final window cycle. First sample after reset: `rate_valid` is high in cycle WINDOW_CYCLES, counting reset release as cycle 0.
- `burst_active` rises the cycle after the first spike of a burst.
- `burst_done`, `burst_len` and `burst_period` update the cycle after the GAP_CYCLES-th silent cycle.
- A spike in the cycle the gap expires is not possible, because expiry needs `spike`=0. A spike one cycle later starts a new burst.
- Reset mid-burst or mid-window discards all partial counts. No `burst_done` is emitted.

## Structure
- Shared package `mtf_pkg`:
  - `RATE_W`=8, `BURST_LEN_W`=8, `PERIOD_W`=16, default WINDOW_CYCLES/GAP_CYCLES.
  - Burst state enum `burst_state_t` {QUIET, BURST}.
- One sub-module: `spike_burst_fsm`, containing the FSM plus length, gap and period counters. The top holds the window counter, rate buffer and handshake.

## Test plan
Unless stated, WINDOW_CYCLES=16, GAP_CYCLES=4, `rate_ready`=1.
- `spike` every 4th cycle from cycle 0 → each window yields `rate`=4 with a one-cycle `rate_valid` pulse. `rate_overrun`=0.
- `rate_ready`=0 for two windows, with 3 then 5 spikes → `rate`=5 and `rate_overrun`=1. After `rate_ready`=1, `rate_valid` drops next cycle and the overrun flag stays 1.
- Spikes on cycles 10,11,13 then silence → `burst_done` pulses at cycle 18, with `burst_len`=3 and `burst_period`=0xFFFF.
- Second burst starting at cycle 30, single spike → its `burst_done` at cycle 35 reports `burst_len`=1 and `burst_period`=20.
- WINDOW_CYCLES=300, `spike` tied high → `rate`=255. No `burst_done`; `burst_active` stays 1. `burst_len` saturates internally at 255, and after `spike` drops for 4 cycles `burst_done` reports 255.
- Assert `reset` at cycle 12 of a burst and mid-window → all outputs return to reset values next cycle. No `burst_done` and no `rate_valid` for the discarded window.
